// File: rtl/rom_boot_copier.sv
`default_nettype none
// ============================================================================
// Module   : rom_boot_copier
// Brief    : Copies boot ROM words 0..WORDS-1 to DEST_BASE+4*i over a Wishbone
//            classic master and holds the CPU in reset until a copy succeeds.
//            Optional running checksum output when ROM_COPY_CSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rom_boot_copier #(
    parameter int          aw        = 5,
    parameter int          WORDS     = 2**aw,
    parameter logic [31:0] DEST_BASE = 32'h0000_0000
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          start_i,
    output logic          rom_en_o,
    output logic [aw-1:0] rom_adr_o,
    input  logic [31:0]   rom_dat_i,
    output logic [31:0]   wbm_adr_o,
    output logic [31:0]   wbm_dat_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic          cpu_rst_o
`ifdef ROM_COPY_CSUM_EN
    ,
    output logic [31:0]   csum_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // One extra index bit so WORDS == 2**aw never wraps the counter.
    localparam logic [aw:0] c_LAST = (aw+1)'(WORDS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [aw:0]   r_idx;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_cpu_rst;
    logic          w_last;
    logic [31:0]   w_adr;

    assign w_last = (r_idx == c_LAST);
    assign w_adr  = DEST_BASE + 32'({r_idx, 2'b00});

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_next = S_RD;
            S_RD:   w_next = S_CAP;
            S_CAP:  w_next = S_WR;
            S_WR: begin
                if (wbm_err_i)      w_next = S_ERR;
                else if (wbm_ack_i) w_next = w_last ? S_DONE : S_RD;
            end
            S_DONE: w_next = S_IDLE;
            S_ERR:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

`ifdef ROM_COPY_CSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_csum <= 32'd0;
        end else if (r_state == S_IDLE && start_i) begin
            r_csum <= 32'd0;
        end else if (r_state == S_WR && wbm_ack_i && !wbm_err_i) begin
            r_csum <= r_csum + r_dat;
        end
    end

    assign csum_o = r_csum;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_idx     <= '0;
            r_adr     <= 32'd0;
            r_dat     <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                S_CAP: begin
                    r_dat <= rom_dat_i;
                    r_adr <= w_adr;
                end
                S_WR: begin
                    // An error beats a simultaneous ack: the word is not counted.
                    if (wbm_err_i) begin
                        r_busy <= 1'b0;
                        r_err  <= 1'b1;
                    end else if (wbm_ack_i) begin
                        if (w_last) begin
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_en_o  = (r_state == S_RD);
    assign rom_adr_o = r_idx[aw-1:0];
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_cyc_o = (r_state == S_WR);
    assign wbm_stb_o = (r_state == S_WR);
    assign wbm_we_o  = (r_state == S_WR);
    assign wbm_sel_o = (r_state == S_WR) ? 4'hF : 4'h0;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign cpu_rst_o = r_cpu_rst;

endmodule
`default_nettype wire

// File: tb/tb_rom_boot_copier.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_boot_copier
// Brief    : Self-checking bench for rom_boot_copier with a ROM model, a
//            stalling/erroring Wishbone slave and a write-log reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_boot_copier;

    localparam int          AW   = 3;
    localparam int          NW   = 8;
    localparam logic [31:0] DEST = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rom_en;
    logic [AW-1:0] rom_adr;
    logic [31:0]   rom_q;
    logic [31:0]   wbm_adr, wbm_dat;
    logic [3:0]    wbm_sel;
    logic          wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err;
    logic          busy, done, err, cpu_rst;
`ifdef ROM_COPY_CSUM_EN
    logic [31:0]   csum;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] rom [NW];
    int          stall_of [NW];
    int          err_word = -1;
    int          wait_cnt = 0;
    logic [31:0] wr_adr [$];
    logic [31:0] wr_dat [$];
    bit          m_cpu_rst = 1'b1;

    always #5 clk = ~clk;

    rom_boot_copier #(.aw(AW), .WORDS(NW), .DEST_BASE(DEST)) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .start_i   (start),
        .rom_en_o  (rom_en),
        .rom_adr_o (rom_adr),
        .rom_dat_i (rom_q),
        .wbm_adr_o (wbm_adr),
        .wbm_dat_o (wbm_dat),
        .wbm_sel_o (wbm_sel),
        .wbm_we_o  (wbm_we),
        .wbm_cyc_o (wbm_cyc),
        .wbm_stb_o (wbm_stb),
        .wbm_ack_i (wbm_ack),
        .wbm_err_i (wbm_err),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .cpu_rst_o (cpu_rst)
`ifdef ROM_COPY_CSUM_EN
        ,
        .csum_o    (csum)
`endif
    );

    // Synchronous-read ROM
    always @(posedge clk) if (rom_en) rom_q <= rom[rom_adr];

    // Slave: acks after stall_of[word] wait cycles; err rides on the ack of err_word.
    logic [31:0] s_word;
    logic        s_hit;
    assign s_word  = (wbm_adr - DEST) >> 2;
    assign s_hit   = wbm_cyc && wbm_stb && (wait_cnt >= stall_of[s_word[AW-1:0]]);
    assign wbm_ack = s_hit;
    assign wbm_err = s_hit && (int'(s_word) == err_word);

    always @(posedge clk) begin
        if (wbm_cyc && wbm_stb && !s_hit) wait_cnt <= wait_cnt + 1;
        else                              wait_cnt <= 0;
        if (s_hit && !wbm_err) begin
            wr_adr.push_back(wbm_adr);
            wr_dat.push_back(wbm_dat);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic randomize_rom();
        for (int i = 0; i < NW; i++) rom[i] = $urandom;
    endtask

    task automatic set_stalls(input int max_stall);
        for (int i = 0; i < NW; i++) stall_of[i] = $urandom_range(0, max_stall);
    endtask

    // One copy; ew<0 means no error, mid>0 pulses an extra start on that cycle.
    task automatic run_copy(input int ew, input int mid);
        int          cycles;
        int          exp_cycles;
        int          nw;
        int          k;
        bit          ok;
        logic [31:0] m_sum;
        wr_adr.delete();
        wr_dat.delete();
        err_word   = ew;
        ok         = (ew < 0);
        nw         = ok ? NW : ew;
        exp_cycles = 0;
        for (int i = 0; i < (ok ? NW : ew + 1); i++) exp_cycles += 3 + stall_of[i];
        m_sum = 32'd0;
        for (int i = 0; i < nw; i++) m_sum += rom[i];

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("err_cleared", err, 0);

        cycles = 0;
        while (cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (cycles == mid);
            if (done || err) break;
            if (wbm_cyc) begin
                k = wr_adr.size();
                if (k < NW) begin
                    chk("bus_adr", wbm_adr, DEST + 32'(k * 4));
                    chk("bus_dat", wbm_dat, rom[k]);
                end
                chk("bus_stb", wbm_stb, 1);
                chk("bus_we", wbm_we, 1);
                chk("bus_sel", wbm_sel, 4'hF);
            end
        end
        start = 1'b0;
        if (ok) m_cpu_rst = 1'b0;

        chk("copy_cycles", cycles, exp_cycles);
        chk("done_flag", done, ok);
        chk("err_flag", err, !ok);
        chk("busy_end", busy, 0);
        chk("cpu_rst_end", cpu_rst, m_cpu_rst);
        chk("write_count", wr_adr.size(), nw);
        for (int i = 0; i < nw && i < wr_adr.size(); i++) begin
            chk("mem_adr", wr_adr[i], DEST + 32'(i * 4));
            chk("mem_dat", wr_dat[i], rom[i]);
        end
`ifdef ROM_COPY_CSUM_EN
        chk("csum_end", csum, m_sum);
`endif

        // A start in the DONE/ERR cycle must be dropped.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_in_final_ignored", busy, 0);
        chk("done_sticky", done, ok);
        chk("err_sticky", err, !ok);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        randomize_rom();
        for (int i = 0; i < NW; i++) stall_of[i] = 0;

        // Reset values
        #23;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cyc", wbm_cyc, 0);
        chk("rst_stb", wbm_stb, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_adr", wbm_adr, 0);
        chk("rst_sel", wbm_sel, 0);
`ifdef ROM_COPY_CSUM_EN
        chk("rst_csum", csum, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Error with ack on word 1 before any success: cpu_rst stays high
        run_copy(1, 0);

        // Zero-wait copy; first two words exercise checksum wrap
        rom[0] = 32'hFFFF_FFFF;
        rom[1] = 32'h0000_0002;
        run_copy(-1, 0);

        // Long stall on word 2, random stalls elsewhere; re-copy keeps cpu_rst low
        randomize_rom();
        set_stalls(2);
        stall_of[2] = 5;
        run_copy(-1, 0);

        // Error after success keeps cpu_rst low
        randomize_rom();
        set_stalls(3);
        run_copy($urandom_range(0, NW - 1), 0);

        // Extra start mid-copy is ignored
        randomize_rom();
        set_stalls(1);
        run_copy(-1, 4);

        // Reset asserted during a WR stall on word 3
        begin
            int n;
            for (int i = 0; i < NW; i++) stall_of[i] = 0;
            stall_of[3] = 50;
            err_word = -1;
            wr_adr.delete();
            wr_dat.delete();
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n = 0;
            while (n < 200 && !(wr_adr.size() == 3 && wbm_cyc && wait_cnt >= 2)) begin
                @(posedge clk);
                #1;
                n++;
                start = (n == 2);
            end
            start = 1'b0;
            #2;
            rst_n = 1'b0;
            #1;
            chk("midrst_cyc", wbm_cyc, 0);
            chk("midrst_stb", wbm_stb, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_cpu_rst", cpu_rst, 1);
            chk("midrst_done", done, 0);
            chk("midrst_writes", wr_adr.size(), 3);
            for (int i = 0; i < 3 && i < wr_adr.size(); i++) begin
                chk("midrst_mem_adr", wr_adr[i], DEST + 32'(i * 4));
                chk("midrst_mem_dat", wr_dat[i], rom[i]);
            end
            m_cpu_rst = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(posedge clk);
            #1;
        end

        // Random recovery copies
        for (int t = 0; t < 3; t++) begin
            randomize_rom();
            set_stalls(3);
            run_copy(-1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
